// File: rtl/mono_tx_pkg.sv
// Shared constants, word layout, FSM encoding and timestamp encoder for the
// MONOPIX serial hit transmitter emulator.
package mono_tx_pkg;

    localparam int WORD_W = 30;
    localparam int COL_W  = 6;
    localparam int ROW_W  = 8;
    localparam int TS_W   = 8;

    localparam int COL_LSB = 0;
    localparam int ROW_LSB = COL_LSB + COL_W;
    localparam int TE_LSB  = ROW_LSB + ROW_W;
    localparam int LE_LSB  = TE_LSB + TS_W;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_HOLD  = 4'b0010,
        ST_SHIFT = 4'b0100,
        ST_DONE  = 4'b1000
    } tx_state_e;

    function automatic logic [TS_W-1:0] gray_enc(input logic [TS_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/mono_tx_hit_fifo.sv
// Single-clock hit FIFO; the extra pointer bit separates full from empty.
module mono_tx_hit_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_fire;
    logic             rd_fire;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mono_data_tx.sv
// MONOPIX hit readout emulator: buffers hits, raises TOKEN, and serializes
// one 30-bit word MSB-first on DATA per READ rising edge.
//
// state | meaning
// IDLE  | no word latched; pops FIFO head when FREEZE is low
// HOLD  | word latched, TOKEN high, waiting for READ rising edge
// SHIFT | word being sent, one bit per cycle
// DONE  | word sent, waiting for READ low
module mono_data_tx
    import mono_tx_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int GRAY_ENCODE = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       HIT_WR,
    input  logic [5:0] HIT_COL,
    input  logic [7:0] HIT_ROW,
    input  logic [7:0] HIT_LE,
    input  logic [7:0] HIT_TE,
    output logic       HIT_FULL,
    input  logic       FREEZE,
    input  logic       READ,
    output logic       TOKEN,
    output logic       DATA,
    output logic [7:0] LOST_CNT,
    output logic       BUSY
);

    tx_state_e         state_q, state_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [WORD_W-2:0] shift_q, shift_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              data_q, data_d;
    logic              read_q;
    logic [7:0]        lost_q, lost_d;

    logic [TS_W-1:0]   le_enc, te_enc;
    logic [WORD_W-1:0] word_in, fifo_head;
    logic              fifo_full, fifo_empty, pop, read_rise;

    assign le_enc  = (GRAY_ENCODE != 0) ? gray_enc(HIT_LE) : HIT_LE;
    assign te_enc  = (GRAY_ENCODE != 0) ? gray_enc(HIT_TE) : HIT_TE;
    assign word_in = {le_enc, te_enc, HIT_ROW, HIT_COL};

    mono_tx_hit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .wr_en   (HIT_WR),
        .wr_data (word_in),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign read_rise = READ & ~read_q;

    always_comb begin
        lost_d = lost_q;
        if (HIT_WR && fifo_full && (lost_q != 8'hFF)) lost_d = lost_q + 8'd1;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !FREEZE) begin
                    pop     = 1'b1;
                    hold_d  = fifo_head;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (read_rise) begin
                    shift_d = hold_q[WORD_W-2:0];
                    data_d  = hold_q[WORD_W-1];
                    cnt_d   = 5'd29;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The MSB is already on DATA; the register keeps the remaining bits.
                if (cnt_q == 5'd0) begin
                    state_d = ST_DONE;
                end else begin
                    data_d  = shift_q[WORD_W-2];
                    shift_d = {shift_q[WORD_W-3:0], 1'b0};
                    cnt_d   = cnt_q - 5'd1;
                end
            end
            ST_DONE: begin
                if (!READ) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= 1'b0;
            read_q  <= 1'b0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            read_q  <= READ;
            lost_q  <= lost_d;
        end
    end

    assign TOKEN    = (state_q == ST_HOLD);
    assign BUSY     = (state_q != ST_IDLE);
    assign DATA     = data_q;
    assign LOST_CNT = lost_q;
    assign HIT_FULL = fifo_full;

endmodule

// File: tb/tb_mono_data_tx.sv
// Scoreboard bench for mono_data_tx: expected words queued at write time,
// serial words captured and compared by an independent monitor.
module tb_mono_data_tx;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       HIT_WR;
    logic [5:0] HIT_COL;
    logic [7:0] HIT_ROW, HIT_LE, HIT_TE;
    logic       HIT_FULL;
    logic       FREEZE, READ;
    logic       TOKEN, DATA, BUSY;
    logic [7:0] LOST_CNT;

    logic rd_auto, rd_man, auto_en;
    logic frz_rnd, frz_man, frz_en;
    logic mon_en;

    int n_cmp = 0;
    int n_err = 0;
    logic [29:0] exp_q[$];

    assign READ   = auto_en ? rd_auto : rd_man;
    assign FREEZE = frz_en ? frz_rnd : frz_man;

    always #5 CLK = ~CLK;

    mono_data_tx #(.DEPTH(8), .GRAY_ENCODE(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .HIT_WR(HIT_WR), .HIT_COL(HIT_COL),
        .HIT_ROW(HIT_ROW), .HIT_LE(HIT_LE), .HIT_TE(HIT_TE), .HIT_FULL(HIT_FULL),
        .FREEZE(FREEZE), .READ(READ), .TOKEN(TOKEN), .DATA(DATA),
        .LOST_CNT(LOST_CNT), .BUSY(BUSY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: word = LE*2^22 + TE*2^14 + ROW*2^6 + COL, timestamps Gray coded.
    function automatic logic [29:0] model_word(input int col, input int row, input int le, input int te);
        int g_le, g_te, w;
        g_le = le ^ (le / 2);
        g_te = te ^ (te / 2);
        w = g_le * 4194304 + g_te * 16384 + row * 64 + col;
        return w[29:0];
    endfunction

    // Drive one hit for one cycle; called at a negedge, returns at the next one.
    task automatic put_hit(input int col, input int row, input int le, input int te, input bit push);
        HIT_COL = col[5:0];
        HIT_ROW = row[7:0];
        HIT_LE  = le[7:0];
        HIT_TE  = te[7:0];
        HIT_WR  = 1'b1;
        if (push) exp_q.push_back(model_word(col, row, le, te));
        @(negedge CLK);
        HIT_WR = 1'b0;
    endtask

    task automatic put_rand_hit(input bit push);
        put_hit($urandom_range(0, 63), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255), push);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || BUSY) && t < budget) begin
            @(negedge CLK);
            t++;
        end
        check(name, {31'b0, t >= budget}, 32'd0);
    endtask

    task automatic wait_token(input string name, input int budget);
        int t = 0;
        while (!TOKEN && t < budget) begin
            @(negedge CLK);
            t++;
        end
        check(name, {31'b0, TOKEN}, 32'd1);
    endtask

    // Monitor: a TOKEN fall while enabled marks a word load; capture 30 bits.
    initial begin : monitor
        logic tok_prev;
        logic [29:0] got;
        logic [29:0] e;
        tok_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (mon_en && RST_N && tok_prev && !TOKEN) begin
                got = {29'b0, DATA};
                for (int i = 1; i < 30; i++) begin
                    @(negedge CLK);
                    got = {got[28:0], DATA};
                end
                @(negedge CLK);
                check("tail_zero", {31'b0, DATA}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {2'b0, got}, {2'b0, e});
                end
            end
            tok_prev = TOKEN;
        end
    end

    // Receiver stand-in: answers TOKEN with a READ pulse of random length.
    initial begin : reader
        rd_auto = 1'b0;
        forever begin
            @(negedge CLK);
            if (auto_en && TOKEN && !rd_auto) begin
                repeat ($urandom_range(0, 3)) @(negedge CLK);
                rd_auto = 1'b1;
                repeat ($urandom_range(1, 40)) @(negedge CLK);
                rd_auto = 1'b0;
            end
        end
    end

    initial begin : freezer
        frz_rnd = 1'b0;
        forever begin
            @(negedge CLK);
            if (frz_en && $urandom_range(0, 9) == 0) frz_rnd = ~frz_rnd;
            if (!frz_en) frz_rnd = 1'b0;
        end
    end

    initial begin : main
        int cnt_a, cnt_b;
        RST_N = 1'b0; HIT_WR = 1'b0; HIT_COL = '0; HIT_ROW = '0; HIT_LE = '0; HIT_TE = '0;
        rd_man = 1'b0; auto_en = 1'b0; frz_man = 1'b0; frz_en = 1'b0; mon_en = 1'b1;

        repeat (3) @(negedge CLK);
        check("rst_token", {31'b0, TOKEN}, 32'd0);
        check("rst_data", {31'b0, DATA}, 32'd0);
        check("rst_lost", {24'b0, LOST_CNT}, 32'd0);
        check("rst_busy", {31'b0, BUSY}, 32'd0);
        check("rst_full", {31'b0, HIT_FULL}, 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Known single word and TOKEN latency.
        check("known_model", {2'b0, model_word(5, 8'h11, 8'h12, 8'h34)}, 32'h06CB_8445);
        put_hit(5, 8'h11, 8'h12, 8'h34, 1'b1);
        check("token_edge_k", {31'b0, TOKEN}, 32'd0);
        @(negedge CLK);
        check("token_edge_k1", {31'b0, TOKEN}, 32'd1);
        rd_man = 1'b1;
        @(negedge CLK);
        check("token_drop_load", {31'b0, TOKEN}, 32'd0);
        repeat (2) @(negedge CLK);
        rd_man = 1'b0;
        wait_drain("single_drain", 200);

        // Overflow under FREEZE.
        frz_man = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            put_rand_hit(i < 8);
            if (i == 6) check("full_after_7", {31'b0, HIT_FULL}, 32'd0);
            if (i == 7) check("full_after_8", {31'b0, HIT_FULL}, 32'd1);
        end
        check("lost_two", {24'b0, LOST_CNT}, 32'd2);
        cnt_a = 0;
        repeat (100) begin
            @(negedge CLK);
            if (TOKEN) cnt_a++;
        end
        check("freeze_no_token", cnt_a, 0);
        frz_man = 1'b0;
        @(negedge CLK);
        check("token_after_unfreeze", {31'b0, TOKEN}, 32'd1);
        auto_en = 1'b1;
        wait_drain("overflow_drain", 3000);
        auto_en = 1'b0;

        // Spurious READ in IDLE.
        rd_man = 1'b1;
        cnt_a = 0; cnt_b = 0;
        repeat (4) begin
            @(negedge CLK);
            if (DATA) cnt_a++;
            if (BUSY) cnt_b++;
        end
        rd_man = 1'b0;
        check("spurious_data", cnt_a, 0);
        check("spurious_busy", cnt_b, 0);
        repeat (2) @(negedge CLK);

        // READ held for 50 cycles: one word, DONE held until READ falls.
        put_rand_hit(1'b1);
        wait_token("hold50_token", 20);
        rd_man = 1'b1;
        repeat (45) @(negedge CLK);
        check("done_busy", {31'b0, BUSY}, 32'd1);
        check("done_token", {31'b0, TOKEN}, 32'd0);
        repeat (5) @(negedge CLK);
        rd_man = 1'b0;
        @(negedge CLK);
        check("done_exit", {31'b0, BUSY}, 32'd0);
        wait_drain("hold50_drain", 100);

        // Randomized bursts with a wandering FREEZE.
        auto_en = 1'b1;
        frz_en  = 1'b1;
        for (int b = 0; b < 12; b++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int h = 0; h < n; h++) begin
                put_rand_hit(1'b1);
                repeat ($urandom_range(0, 2)) @(negedge CLK);
            end
            wait_drain("rand_drain", 4000);
        end
        frz_en = 1'b0;
        check("lost_stable", {24'b0, LOST_CNT}, 32'd2);
        repeat (3) @(negedge CLK);
        auto_en = 1'b0;

        // Reset in the middle of a word.
        mon_en = 1'b0;
        put_hit(6'h3F, 8'hFF, 8'h00, 8'h00, 1'b0);
        wait_token("rst_mid_token", 20);
        rd_man = 1'b1;
        @(negedge CLK);
        repeat (17) @(negedge CLK);
        check("pre_rst_bit12", {31'b0, DATA}, 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check("mid_rst_data", {31'b0, DATA}, 32'd0);
        check("mid_rst_token", {31'b0, TOKEN}, 32'd0);
        check("mid_rst_lost", {24'b0, LOST_CNT}, 32'd0);
        check("mid_rst_busy", {31'b0, BUSY}, 32'd0);
        rd_man = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        cnt_a = 0;
        repeat (20) begin
            @(negedge CLK);
            if (TOKEN || DATA) cnt_a++;
        end
        check("post_rst_quiet", cnt_a, 0);
        mon_en = 1'b1;
        @(negedge CLK);
        put_rand_hit(1'b1);
        auto_en = 1'b1;
        wait_drain("post_rst_drain", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mono_data_tx.md
Name: mono_data_tx

Overview:
- Chip-side emulator of the MONOPIX serial hit readout. It is the transmitter partner of the existing data receiver.
- Buffers injected hits and raises TOKEN while a hit is pending. It obeys FREEZE, and on a READ rising edge shifts one 30-bit hit word out MSB-first on DATA.
- Used in simulation benches and in the FPGA loopback test to drive the receiver without a sensor.

Parameters:
- DEPTH, 8, hit FIFO depth in words (power of two, at least 2).
- GRAY_ENCODE, 1, if 1, LE and TE are binary-to-Gray encoded before transmission; if 0, they are sent raw.

Ports:
- CLK  in  1  single clock; the receiver's RX_CLK and CLK_BX are driven from the same clock.
- RST_N  in  1  asynchronous, active-low reset.
- HIT_WR  in  1  write strobe for one hit.
- HIT_COL  in  6  column.
- HIT_ROW  in  8  row.
- HIT_LE  in  8  leading-edge timestamp, binary.
- HIT_TE  in  8  trailing-edge timestamp, binary.
- HIT_FULL  out  1  hit FIFO full.
- FREEZE  in  1  freeze request from the receiver.
- READ  in  1  read request from the receiver.
- TOKEN  out  1  a hit word is latched and waiting to be read.
- DATA  out  1  serial data.
- LOST_CNT  out  8  hits dropped on full, saturating counter.
- BUSY  out  1  state is not IDLE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - FIFO is emptied; state goes to IDLE; shift register, bit counter and the READ sample flop are cleared.
  - Outputs during reset: TOKEN=0, DATA=0, LOST_CNT=0, BUSY=0, HIT_FULL=0.
  - Release takes effect on the next CLK edge.
- Word format: {LE[29:22], TE[21:14], ROW[13:6], COL[5:0]}.
  - Encoding applied at write time: g = b ^ (b>>1).
- FIFO write:
  - A hit is stored on an edge where HIT_WR=1 and the FIFO is not full.
  - HIT_WR while full drops the hit and increments LOST_CNT, which saturates at 255.
  - A simultaneous write and pop on a full FIFO is treated as full: the write is dropped.
- READ edge detection: read_q registers READ; read_rise = READ & ~read_q.
- IDLE:
  - If the FIFO is non-empty and FREEZE=0, pop the head word into the holding register and go to HOLD.
  - TOKEN is registered high from that edge.
  - Latency: HIT_WR at edge k gives TOKEN=1 after edge k+1.
  - While FREEZE=1, no pop occurs and TOKEN stays 0.
  - A read_rise in IDLE is ignored.
- HOLD:
  - TOKEN=1. FREEZE has no effect.
  - On read_rise, load the shift register from the holding register, set bit counter=29 and go to SHIFT.
  - From that edge: TOKEN=0 and DATA=word[29].
- SHIFT:
  - Each edge shifts left one bit; DATA is registered and equals the current MSB.
  - Exactly 30 bits are sent, bits 29 down to 0, on 30 consecutive cycles.
  - When the counter reaches 0, the next edge sets DATA=0 and goes to DONE.
  - READ falling mid-word does not abort the word.
- DONE: wait until READ=0, then go to IDLE.
  - This guarantees one word per read pulse.
  - Next-word TOKEN can rise at the earliest 1 cycle after DONE exits, if FREEZE=0.
- DATA is 0 in every state except SHIFT.
- Reset mid-SHIFT: the word is lost and DATA drops to 0 immediately.
- BUSY = (state != IDLE).

Decomposition:
- Package mono_tx_pkg holds:
  - WORD_W=30, COL_W=6, ROW_W=8, TS_W=8;
  - field bit offsets;
  - state enum IDLE/HOLD/SHIFT/DONE, one-hot;
  - the gray_enc function.
- One sub-module, mono_tx_hit_fifo:
  - single-clock FIFO, async active-low reset, DEPTH words, full/empty flags;
  - pointer width log2(DEPTH)+1 so full and empty are distinguished.

Test Plan:
- Single hit, GRAY_ENCODE=1: HIT_WR with COL=5, ROW=0x11, LE=0x12, TE=0x34 at edge k -> TOKEN=1 after edge k+1. A READ pulse then produces DATA serializing 0x6CB8445 MSB-first over 30 cycles, TOKEN=0 from the load edge, then DATA=0.
- Loopback with the receiver (default receiver config, Gray decode enabled), 3 hits -> receiver FIFO returns exactly the 3 binary words in order; receiver LOST_ERROR=0.
- Overflow, DEPTH=8, FREEZE=1: 10 back-to-back HIT_WR -> HIT_FULL=1 after the 8th write; LOST_CNT=2. After FREEZE drops, 8 words are read in order.
- FREEZE held high with the FIFO non-empty -> TOKEN stays 0 for 100 cycles. TOKEN=1 one edge after FREEZE falls.
- Spurious READ in IDLE -> DATA stays 0 and state stays IDLE. READ held high for 50 cycles in HOLD -> exactly 30 bits sent, DONE held until READ falls.
- RST_N asserted at bit 12 of SHIFT -> DATA=0, TOKEN=0, LOST_CNT=0 immediately. After release, no token appears until a new hit is written.
